// File: rtl/axil_arb_pkg.sv
// axil_arb_pkg: state encoding and response codes shared by the AXI4-Lite master arbiter
package axil_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_TIMEOUT = 1'b1;
endpackage

// File: rtl/axil_rr_picker.sv
// axil_rr_picker: combinational round-robin pick, first set request at or after ptr
module axil_rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int PW = $clog2(N);
  // Scan from the farthest offset down so the nearest hit to ptr is the one kept
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        gnt = N'(1) << ((int'(ptr) + i) % N);
        idx = PW'((int'(ptr) + i) % N);
      end
  end
  assign any = |req;
endmodule

// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: round-robin sharing of one AXI4-Lite master command port,
// one transaction in flight, with a response timeout guarding against a hung slave
module axil_master_arbiter
  import axil_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         m_addr,
  output logic                      m_write,
  output logic [DATA_W-1:0]         m_wdata,
  output logic                      m_transfer,
  input  logic                      m_ready,
  input  logic [DATA_W-1:0]         m_rdata,
  output logic                      timeout_sticky
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  arb_state_e state;
  logic [PW-1:0] rr_ptr, grant, win;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] gnt;
  logic any;
  axil_rr_picker #(.N(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(win),
    .any(any)
  );
  assign req_ready = (state == ARB_IDLE) ? gnt : '0;
  // m_addr/m_write/m_wdata double as the capture registers for the granted request
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      grant          <= '0;
      cnt            <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= RESP_OKAY;
      m_addr         <= '0;
      m_write        <= 1'b0;
      m_wdata        <= '0;
      m_transfer     <= 1'b0;
      timeout_sticky <= 1'b0;
    end else begin
      m_transfer <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= RESP_OKAY;
      case (state)
        ARB_IDLE:
          if (any) begin
            grant      <= win;
            m_write    <= req_write[win];
            m_addr     <= req_addr[win*ADDR_W +: ADDR_W];
            m_wdata    <= req_wdata[win*DATA_W +: DATA_W];
            m_transfer <= 1'b1;
            state      <= ARB_ISSUE;
          end
        ARB_ISSUE: begin
          cnt   <= '0;
          state <= ARB_WAIT;
        end
        ARB_WAIT: begin
          cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
          if (m_ready) begin
            rsp_valid <= NUM_REQ'(1) << grant;
            rsp_rdata <= m_write ? '0 : m_rdata;
            state     <= ARB_RESP;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            rsp_valid      <= NUM_REQ'(1) << grant;
            rsp_err        <= RESP_TIMEOUT;
            timeout_sticky <= 1'b1;
            state          <= ARB_RESP;
          end
        end
        default: begin
          rr_ptr <= (grant == PW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          state  <= ARB_IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_axil_master_arbiter.sv
// tb_axil_master_arbiter: directed and random stimulus against a transaction-level
// model of round-robin granting, slave reply timing and timeouts
module tb_axil_master_arbiter;
  localparam int N = 4, AW = 4, DW = 32, TO = 16;
  logic ACLK = 1'b0, ARESET = 1'b1;
  logic [N-1:0] req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic rsp_err, m_write, m_transfer, m_ready, timeout_sticky;
  always #5 ACLK = ~ACLK;
  axil_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_addr(m_addr), .m_write(m_write), .m_wdata(m_wdata), .m_transfer(m_transfer),
    .m_ready(m_ready), .m_rdata(m_rdata), .timeout_sticky(timeout_sticky)
  );
  int checks = 0, failures = 0;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // model state: one outstanding transaction, remembered by the cycles it must hit
  int cyc = 0, own = 0, acc_cyc = 0, rsp_cyc = -1, ready_cyc = -1, last = N - 1;
  bit busy = 0, own_wr = 0, exp_err = 0, exp_sticky = 0, just_acc = 0;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata, sdata, seen_rdata;
  int slave_dly = -1;
  bit auto_drop = 1, spur = 0, beef = 0, seen_err = 0;
  int glog[$];
  int n_acc = 0, n_rsp = 0, seen_acc_cyc = 0, seen_rsp_cyc = 0;
  task automatic tick();
    logic [N-1:0] exp_rdy, ev;
    logic [DW-1:0] edata;
    int w, d;
    @(negedge ACLK);
    exp_rdy = '0;
    w = -1;
    if (!busy)
      for (int o = 0; o < N; o++)
        if (w < 0 && req_valid[(last + 1 + o) % N]) w = (last + 1 + o) % N;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    if (req_ready != 0) begin
      seen_acc_cyc = cyc;
      for (int i = 0; i < N; i++) if (req_ready[i]) glog.push_back(i);
    end
    just_acc = 0;
    if (w >= 0) begin
      busy = 1; own = w; last = w; acc_cyc = cyc; rsp_cyc = -1; ready_cyc = -1;
      own_wr = req_write[w];
      own_addr = req_addr[w*AW +: AW];
      own_wdata = req_wdata[w*DW +: DW];
      n_acc++;
      just_acc = 1;
    end
    check("m_transfer", m_transfer, busy && cyc == acc_cyc + 1);
    if (busy && cyc == acc_cyc + 1) begin
      d = slave_dly >= 0 ? slave_dly : (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12)));
      sdata = beef ? 32'hDEADBEEF : $urandom;
      exp_err = (d == 0 || d > TO);
      ready_cyc = exp_err ? -1 : cyc + d;
      rsp_cyc = cyc + (exp_err ? TO : d) + 1;
    end
    if (busy && cyc > acc_cyc)
      check("m_hold", {m_addr, m_write, m_wdata}, {own_addr, own_wr, own_wdata});
    if (busy && cyc == rsp_cyc) begin
      ev = '0;
      ev[own] = 1'b1;
      edata = (exp_err || own_wr) ? '0 : sdata;
      if (exp_err) exp_sticky = 1;
      check("rsp", {rsp_valid, rsp_err, rsp_rdata}, {ev, exp_err, edata});
      busy = 0;
    end else
      check("rsp_valid", rsp_valid, '0);
    if (rsp_valid != 0) begin
      n_rsp++; seen_rsp_cyc = cyc; seen_rdata = rsp_rdata; seen_err = rsp_err;
    end
    check("sticky", timeout_sticky, exp_sticky);
    @(posedge ACLK);
    #1;
    cyc++;
    m_ready = (cyc == ready_cyc) || spur;
    m_rdata = (cyc == ready_cyc) ? sdata : $urandom;
    if (just_acc && auto_drop) req_valid[own] = 1'b0;
  endtask
  task automatic do_reset();
    ARESET = 1'b1; req_valid = '0; m_ready = 1'b0; spur = 0;
    busy = 0; last = N - 1; exp_sticky = 0; ready_cyc = -1; rsp_cyc = -1;
    @(negedge ACLK);
    check("reset_outs", {req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_write, m_wdata,
                         m_transfer, timeout_sticky}, '0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    cyc++;
  endtask
  task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask
  task automatic wait_idle(input int lim);
    int k = 0;
    while ((busy || req_valid != 0) && k < lim) begin
      tick();
      k++;
    end
    check("idle_bound", k < lim, 1);
  endtask
  initial begin
    int k, n0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; m_ready = 1'b0; m_rdata = '0;
    do_reset();
    // single read, slave replies 3 cycles after the transfer
    slave_dly = 3; beef = 1;
    set_req(2, 0, 4'h8, 32'h0);
    tick();
    wait_idle(40);
    check("t2_grant", glog[glog.size() - 1], 2);
    check("t2_latency", seen_rsp_cyc - seen_acc_cyc, 5);
    check("t2_rdata", seen_rdata, 32'hDEADBEEF);
    beef = 0;
    // fairness with every requester holding a write request
    do_reset();
    glog.delete();
    slave_dly = -1; auto_drop = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 4'(4 + i), 32'hA000_0000 + i);
    k = 0;
    while (glog.size() < 6 && k < 300) begin
      tick();
      k++;
    end
    req_valid = '0; auto_drop = 1;
    wait_idle(60);
    check("t3_count", glog.size() >= 6, 1);
    for (int i = 0; i < 6; i++) check("t3_order", glog[i], i % N);
    // reset while waiting on the slave abandons the transaction
    slave_dly = 0;
    set_req(1, 0, 4'h3, 32'h0);
    repeat (4) tick();
    do_reset();
    n0 = n_rsp;
    repeat (30) tick();
    check("t1_no_rsp", n_rsp, n0);
    // timeout, then a stray m_ready while idle
    slave_dly = 0;
    set_req(1, 0, 4'h5, 32'h0);
    tick();
    wait_idle(60);
    check("t4_latency", seen_rsp_cyc - seen_acc_cyc, TO + 2);
    check("t4_err", seen_err, 1);
    check("t4_rdata", seen_rdata, 0);
    check("t4_sticky", timeout_sticky, 1);
    n0 = n_rsp;
    spur = 1;
    tick();
    spur = 0;
    repeat (6) tick();
    check("t4_late", n_rsp, n0);
    // pointer wrap and lowest priority for the last winner
    do_reset();
    glog.delete();
    slave_dly = 2;
    set_req(2, 0, 4'h1, 32'h0);
    tick();
    wait_idle(40);
    set_req(0, 1, 4'h2, 32'h11);
    set_req(3, 1, 4'h3, 32'h33);
    tick();
    wait_idle(60);
    set_req(1, 0, 4'h6, 32'h0);
    set_req(2, 0, 4'h7, 32'h0);
    tick();
    wait_idle(60);
    check("t5_first", glog[1], 3);
    check("t5_wrap", glog[2], 0);
    check("t5_next", glog[3], 1);
    // random traffic with random reply delays and occasional hung slave
    do_reset();
    slave_dly = -1; n_acc = 0; n_rsp = 0; k = 0;
    while (n_acc < 1500 && k < 60000) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && !(busy && own == i) && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom), 4'($urandom), $urandom);
        else if (req_valid[i] && $urandom_range(0, 31) == 0)
          req_valid[i] = 1'b0;
      tick();
      k++;
    end
    req_valid = '0;
    wait_idle(100);
    check("t6_bound", k < 60000, 1);
    check("t6_acc_rsp", n_rsp, n_acc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
